hazard_md_ctrl: RTL and testbench
=================================

Name: hazard_md_ctrl

Overview:
- Central hazard controller and scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).
- Compares D/E source registers against E/M/W destination tags, using Tuse/Tnew timing to decide between forwarding and stalling.
- Owns the busy counter for the multi-cycle HI/LO multiply/divide unit. Stalls D-stage HI/LO instructions until the unit is free.
- Outputs drive PC/IF_ID enable, the ID_EX bubble, and forwarding muxes. It also keeps a saturating stall-cycle counter.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu, counted after the E-stage start cycle.
- DIV_LAT, 10, busy cycles for div/divu.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- D_rs, D_rt  in  5 each  D-stage source register numbers
- D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until the D instruction needs the operand; 3 = unused
- D_is_md  in  1  D instruction reads or writes HI/LO (mult, div, mfhi, mflo, mthi, mtlo)
- E_rs, E_rt  in  5 each  E-stage source register numbers
- E_WR, M_WR, W_WR  in  5 each  destination register per stage
- RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  stage writes the GRF
- Tnew_E, Tnew_M  in  3 each  cycles until the stage's result exists; W is implicitly 0
- md_start  in  1  mult/div is in E this cycle
- md_is_div  in  1  qualifies md_start: 1 = div, 0 = mult
- stall  out  1  freeze PC and IF_ID, bubble ID_EX
- fwd_D_rs, fwd_D_rt  out  2 each  0 = GRF, 1 = E, 2 = M, 3 = W
- fwd_E_rs, fwd_E_rt  out  2 each  0 = pipeline value, 2 = M, 3 = W (1 unused)
- md_busy  out  1  MD unit occupied
- md_done  out  1  one-cycle pulse when the busy count reaches 0
- md_err  out  1  sticky: md_start arrived while busy
- stall_cnt  out  CNT_W  cycles with stall = 1, saturating

Behaviour:
- Register match, for stage X and source s: s != 0 && s == X_WR && RegWrite_X.
- Data stall (combinational):
  - Asserted when a D source matches E and Tuse < Tnew_E.
  - Or when a D source matches M and Tuse < Tnew_M.
  - W never causes a stall.
  - Tuse = 3 never stalls.
- MD stall (combinational): D_is_md && (md_busy || md_start).
- stall = data stall OR MD stall. No registered delay.
- D forwarding:
  - Priority E > M > W.
  - A stage is eligible only on a match with its Tnew == 0 (W always eligible).
  - If no stage is eligible, select 0.
  - Forwarding outputs are valid even while stall = 1.
- E forwarding: priority M > W, same eligibility rule.
- MD counter `cnt` (4 bits minimum, sized to the larger of MULT_LAT/DIV_LAT):
  - On md_start while cnt == 0: load DIV_LAT if md_is_div, else MULT_LAT.
  - Otherwise, if cnt != 0: decrement by 1.
  - md_busy = (cnt != 0), registered.
- md_done:
  - Registered. Set for exactly one cycle in the cycle after cnt transitions 1 -> 0.
  - The counter does not reload in the cycle md_done is high unless md_start is asserted.
- md_start while cnt != 0:
  - Command ignored; the counter keeps decrementing.
  - md_err sets and holds until reset.
- stall_cnt: increments each cycle stall = 1; holds at all-ones.
- Reset (synchronous, including mid-operation):
  - cnt = 0, md_busy = 0, md_done = 0, md_err = 0, stall_cnt = 0.
  - The combinational outputs follow the inputs, which the upstream pipeline registers clear to 0.
  - With all inputs at 0, stall = 0 and all fwd selects = 0.
- Simultaneous events:
  - md_start and D_is_md in the same cycle: stall. The counter loads on that edge.
  - Data stall and MD stall together: a single stall. stall_cnt adds 1.

Test Plan:
- Load-use: D_rs = 8, D_Tuse_rs = 0; E_WR = 8, RegWrite_E = 1, Tnew_E = 2 -> stall = 1.
  - Next cycle, with M_WR = 8 and Tnew_M = 1 -> stall = 1.
  - Then W_WR = 8 -> stall = 0, fwd_D_rs = 3.
- Priority: D_rt = 9 matches E (Tnew 0), M (Tnew 0) and W -> fwd_D_rt = 1.
  - Same with E_rt = 9 matched in M and W -> fwd_E_rt = 2.
  - Register $0 matched in every stage -> all fwd selects = 0, stall = 0.
- Mult: md_start = 1, md_is_div = 0 at cycle t -> md_busy = 1 for cycles t+1..t+5, md_done = 1 at t+6.
  - D_is_md = 1 throughout -> stall = 1 for t..t+5, 0 at t+6.
- Div with reset at the 4th busy cycle -> next cycle md_busy = 0, md_done never pulses, stall_cnt = 0.
- Restart: md_start during busy -> md_err = 1 and held; the busy window is not extended.
  - Reset clears md_err.
- Saturation: force 70000 stall cycles with CNT_W = 16 -> stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl: hazard controller and scheduler for the 5-stage MIPS pipeline.
//
// Compares D/E source registers against E/M/W destinations and uses Tuse/Tnew
// timing to choose between forwarding and stalling. Tracks occupancy of the
// multi-cycle HI/LO multiply/divide unit and keeps a saturating stall counter.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   D_rs, D_rt, D_Tuse_rs/rt        D-stage sources and their use times (3 = unused)
//   D_is_md                         D instruction touches HI/LO
//   E_rs, E_rt                      E-stage sources
//   E_WR, M_WR, W_WR, RegWrite_*    destination tags and write enables
//   Tnew_E, Tnew_M                  cycles until the stage's result exists
//   md_start, md_is_div             mult/div entering E this cycle
//   stall                           freeze PC/IF_ID, bubble ID_EX
//   fwd_D_rs/rt                     0 = GRF, 1 = E, 2 = M, 3 = W
//   fwd_E_rs/rt                     0 = pipeline value, 2 = M, 3 = W
//   md_busy, md_done, md_err        MD unit status
//   stall_cnt                       saturating count of stall cycles
module hazard_md_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic [1:0]       D_Tuse_rs,
    input  logic [1:0]       D_Tuse_rt,
    input  logic             D_is_md,
    input  logic [4:0]       E_rs,
    input  logic [4:0]       E_rt,
    input  logic [4:0]       E_WR,
    input  logic [4:0]       M_WR,
    input  logic [4:0]       W_WR,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic [2:0]       Tnew_E,
    input  logic [2:0]       Tnew_M,
    input  logic             md_start,
    input  logic             md_is_div,
    output logic             stall,
    output logic [1:0]       fwd_D_rs,
    output logic [1:0]       fwd_D_rt,
    output logic [1:0]       fwd_E_rs,
    output logic [1:0]       fwd_E_rt,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned LatW   = ($clog2(MaxLat + 1) > 4) ? $clog2(MaxLat + 1) : 4;
    localparam logic [LatW-1:0] MultLd = LatW'(MULT_LAT);
    localparam logic [LatW-1:0] DivLd  = LatW'(DIV_LAT);

    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] wr,
                                       input logic we);
        return (src != 5'd0) && (src == wr) && we;
    endfunction

    // A source stalls only if a producer in E or M will not have its result in time.
    function automatic logic src_stall(input logic me, input logic mm, input logic [1:0] tuse,
                                       input logic [2:0] te, input logic [2:0] tm);
        if (tuse == 2'd3) return 1'b0;
        return (me && ({1'b0, tuse} < te)) || (mm && ({1'b0, tuse} < tm));
    endfunction

    function automatic logic [1:0] sel_d(input logic me, input logic mm, input logic mw,
                                         input logic [2:0] te, input logic [2:0] tm);
        if (me && te == 3'd0) return 2'd1;
        if (mm && tm == 3'd0) return 2'd2;
        if (mw)               return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic mm, input logic mw, input logic [2:0] tm);
        if (mm && tm == 3'd0) return 2'd2;
        if (mw)               return 2'd3;
        return 2'd0;
    endfunction

    logic [LatW-1:0]  cnt_q, cnt_d;
    logic             md_done_q, md_done_d;
    logic             md_err_q, md_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             data_stall, md_stall;

    always_comb begin
        data_stall = src_stall(reg_match(D_rs, E_WR, RegWrite_E), reg_match(D_rs, M_WR, RegWrite_M),
                               D_Tuse_rs, Tnew_E, Tnew_M)
                   | src_stall(reg_match(D_rt, E_WR, RegWrite_E), reg_match(D_rt, M_WR, RegWrite_M),
                               D_Tuse_rt, Tnew_E, Tnew_M);
        // md_start covers the cycle the op sits in E before the counter is loaded.
        md_stall   = D_is_md && ((cnt_q != '0) || md_start);
        stall      = data_stall | md_stall;

        fwd_D_rs = sel_d(reg_match(D_rs, E_WR, RegWrite_E), reg_match(D_rs, M_WR, RegWrite_M),
                         reg_match(D_rs, W_WR, RegWrite_W), Tnew_E, Tnew_M);
        fwd_D_rt = sel_d(reg_match(D_rt, E_WR, RegWrite_E), reg_match(D_rt, M_WR, RegWrite_M),
                         reg_match(D_rt, W_WR, RegWrite_W), Tnew_E, Tnew_M);
        fwd_E_rs = sel_e(reg_match(E_rs, M_WR, RegWrite_M), reg_match(E_rs, W_WR, RegWrite_W),
                         Tnew_M);
        fwd_E_rt = sel_e(reg_match(E_rt, M_WR, RegWrite_M), reg_match(E_rt, W_WR, RegWrite_W),
                         Tnew_M);
    end

    always_comb begin
        cnt_d       = cnt_q;
        md_done_d   = 1'b0;
        md_err_d    = md_err_q;
        stall_cnt_d = stall_cnt_q;

        if (md_start && cnt_q == '0) begin
            cnt_d = md_is_div ? DivLd : MultLd;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        // cnt == 1 always drains to 0 on this edge, so done shows next cycle.
        md_done_d = (cnt_q == LatW'(1));
        if (md_start && cnt_q != '0) md_err_d = 1'b1;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            md_done_q   <= 1'b0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            md_done_q   <= md_done_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = (cnt_q != '0);
    assign md_done   = md_done_q;
    assign md_err    = md_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Testbench for hazard_md_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-number based behavioural model.
module tb_hazard_md_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 16;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] D_rs, D_rt, E_rs, E_rt, E_WR, M_WR, W_WR;
    logic [1:0] D_Tuse_rs, D_Tuse_rt;
    logic D_is_md, RegWrite_E, RegWrite_M, RegWrite_W, md_start, md_is_div;
    logic [2:0] Tnew_E, Tnew_M;
    logic stall, md_busy, md_done, md_err;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad = 0;

    // Model state: current cycle number, cycle at which the MD op finishes.
    int cyc = 1;
    int md_end = 0;
    bit m_err = 0;
    int m_scnt = 0;

    hazard_md_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_is_md(D_is_md), .E_rs(E_rs), .E_rt(E_rt),
        .E_WR(E_WR), .M_WR(M_WR), .W_WR(W_WR),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .md_start(md_start), .md_is_div(md_is_div),
        .stall(stall), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
        .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt),
        .md_busy(md_busy), .md_done(md_done), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy();
        return cyc < md_end;
    endfunction

    function automatic bit m_done();
        return (md_end != 0) && (cyc == md_end);
    endfunction

    // Stage tables indexed 0 = E, 1 = M, 2 = W; first eligible in priority order wins.
    function automatic int exp_fwd(input logic [4:0] s, input int first);
        logic [4:0] wr [3];
        bit we [3];
        int tn [3];
        wr[0] = E_WR; wr[1] = M_WR; wr[2] = W_WR;
        we[0] = RegWrite_E; we[1] = RegWrite_M; we[2] = RegWrite_W;
        tn[0] = int'(Tnew_E); tn[1] = int'(Tnew_M); tn[2] = 0;
        for (int i = first; i < 3; i++)
            if (s != 0 && s == wr[i] && we[i] && tn[i] == 0) return i + 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        logic [4:0] wr [2];
        bit we [2];
        int tn [2];
        logic [4:0] src [2];
        int tu [2];
        wr[0] = E_WR; wr[1] = M_WR;
        we[0] = RegWrite_E; we[1] = RegWrite_M;
        tn[0] = int'(Tnew_E); tn[1] = int'(Tnew_M);
        src[0] = D_rs; src[1] = D_rt;
        tu[0] = int'(D_Tuse_rs); tu[1] = int'(D_Tuse_rt);
        for (int k = 0; k < 2; k++)
            if (tu[k] != 3)
                for (int i = 0; i < 2; i++)
                    if (src[k] != 0 && src[k] == wr[i] && we[i] && tu[k] < tn[i]) return 1;
        return D_is_md && (m_busy() || md_start);
    endfunction

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        bit st;
        st = exp_stall();
        if (reset) begin
            md_end = 0; m_err = 0; m_scnt = 0;
        end else begin
            if (md_start) begin
                if (m_busy()) m_err = 1;
                else md_end = cyc + 1 + (md_is_div ? DIV_LAT : MULT_LAT);
            end
            if (st && m_scnt < MAXC) m_scnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        {D_rs, D_rt, E_rs, E_rt, E_WR, M_WR, W_WR} = '0;
        {D_Tuse_rs, D_Tuse_rt} = '0;
        {D_is_md, RegWrite_E, RegWrite_M, RegWrite_W, md_start, md_is_div} = '0;
        Tnew_E = '0; Tnew_M = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt} !== 8'd0) begin
            bad++; $display("FAIL reset_fwd got=%h exp=00", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt});
        end
        total++; if ({md_busy, md_done, md_err} !== 3'b000) begin
            bad++; $display("FAIL reset_md got=%b exp=000", {md_busy, md_done, md_err});
        end
        total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_scnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        D_rs = 8; D_Tuse_rs = 0; E_WR = 8; RegWrite_E = 1; Tnew_E = 2;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_e_stall got=%b exp=1", stall); end
        tick();
        E_WR = 0; RegWrite_E = 0; Tnew_E = 0; M_WR = 8; RegWrite_M = 1; Tnew_M = 1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_m_stall got=%b exp=1", stall); end
        tick();
        M_WR = 0; RegWrite_M = 0; Tnew_M = 0; W_WR = 8; RegWrite_W = 1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_w_stall got=%b exp=0", stall); end
        total++; if (fwd_D_rs !== 2'd3) begin bad++; $display("FAIL lu_w_fwd got=%0d exp=3", fwd_D_rs); end
        tick();
        total++; if (int'(stall_cnt) !== m_scnt || m_scnt != 2) begin
            bad++; $display("FAIL lu_scnt got=%0d exp=%0d", stall_cnt, m_scnt);
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        D_rt = 9; E_rt = 9; E_WR = 9; M_WR = 9; W_WR = 9;
        RegWrite_E = 1; RegWrite_M = 1; RegWrite_W = 1;
        #1;
        total++; if (fwd_D_rt !== 2'd1) begin bad++; $display("FAIL prio_d_rt got=%0d exp=1", fwd_D_rt); end
        total++; if (fwd_E_rt !== 2'd2) begin bad++; $display("FAIL prio_e_rt got=%0d exp=2", fwd_E_rt); end
        Tnew_E = 1;
        D_Tuse_rt = 2;
        #1;
        total++; if (fwd_D_rt !== 2'd2 || stall !== 1'b0) begin
            bad++; $display("FAIL prio_e_late got=%0d/%b exp=2/0", fwd_D_rt, stall);
        end
        tick();
        clear_inputs();
        RegWrite_E = 1; RegWrite_M = 1; RegWrite_W = 1; Tnew_E = 2; Tnew_M = 1;
        #1;
        total++; if ({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, stall} !== 9'd0) begin
            bad++; $display("FAIL prio_r0 got=%h stall=%b exp=00/0",
                            {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt}, stall);
        end
        tick();
    endtask

    task automatic test_mult();
        clear_inputs();
        D_is_md = 1; md_start = 1; md_is_div = 0;
        #1;
        total++; if (stall !== 1'b1 || md_busy !== 1'b0) begin
            bad++; $display("FAIL mult_t0 got=%b/%b exp=1/0", stall, md_busy);
        end
        tick();
        md_start = 0;
        for (int k = 1; k <= MULT_LAT; k++) begin
            #1;
            total++; if ({md_busy, stall, md_done} !== 3'b110) begin
                bad++; $display("FAIL mult_busy_%0d got=%b exp=110", k, {md_busy, stall, md_done});
            end
            tick();
        end
        total++; if ({md_busy, stall, md_done} !== 3'b001) begin
            bad++; $display("FAIL mult_done got=%b exp=001", {md_busy, stall, md_done});
        end
        tick();
        total++; if (md_done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", md_done); end
        D_is_md = 0;
    endtask

    task automatic test_div_reset();
        bit seen_done;
        clear_inputs();
        D_is_md = 1; md_start = 1; md_is_div = 1;
        tick();
        md_start = 0;
        tick(); tick(); tick();
        #1;
        total++; if (md_busy !== 1'b1 || int'(stall_cnt) !== m_scnt) begin
            bad++; $display("FAIL div_busy4 got=%b/%0d exp=1/%0d", md_busy, stall_cnt, m_scnt);
        end
        reset = 1;
        tick();
        reset = 0;
        #1;
        total++; if ({md_busy, stall} !== 2'b00 || stall_cnt !== '0) begin
            bad++; $display("FAIL div_rst got=%b/%0d exp=00/0", {md_busy, stall}, stall_cnt);
        end
        D_is_md = 0;
        seen_done = 0;
        for (int k = 0; k < DIV_LAT + 3; k++) begin
            if (md_done === 1'b1) seen_done = 1;
            tick();
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL div_rst_done got=1 exp=0"); end
    endtask

    task automatic test_restart();
        clear_inputs();
        md_start = 1;
        tick();
        tick();
        md_start = 0;
        #1;
        total++; if (md_err !== 1'b1) begin bad++; $display("FAIL rst_err got=%b exp=1", md_err); end
        tick(); tick(); tick(); tick();
        total++; if ({md_busy, md_done} !== 2'b01) begin
            bad++; $display("FAIL restart_window got=%b exp=01", {md_busy, md_done});
        end
        tick(); tick();
        total++; if (md_err !== 1'b1) begin bad++; $display("FAIL err_hold got=%b exp=1", md_err); end
        reset = 1;
        tick();
        reset = 0;
        total++; if (md_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", md_err); end
    endtask

    task automatic test_random();
        int e;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
            E_rs = 5'($urandom_range(0, 3)); E_rt = 5'($urandom_range(0, 3));
            E_WR = 5'($urandom_range(0, 3)); M_WR = 5'($urandom_range(0, 3));
            W_WR = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3)); D_Tuse_rt = 2'($urandom_range(0, 3));
            RegWrite_E = 1'($urandom); RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
            Tnew_E = 3'($urandom_range(0, 4)); Tnew_M = 3'($urandom_range(0, 2));
            D_is_md = ($urandom_range(0, 3) == 0);
            md_start = ($urandom_range(0, 9) == 0);
            md_is_div = 1'($urandom);
            #1;
            e = exp_stall();
            total++; if (stall !== 1'(e)) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%0d", n, stall, e); end
            e = exp_fwd(D_rs, 0);
            total++; if (fwd_D_rs !== 2'(e)) begin bad++; $display("FAIL rnd_fdrs n=%0d got=%0d exp=%0d", n, fwd_D_rs, e); end
            e = exp_fwd(D_rt, 0);
            total++; if (fwd_D_rt !== 2'(e)) begin bad++; $display("FAIL rnd_fdrt n=%0d got=%0d exp=%0d", n, fwd_D_rt, e); end
            e = exp_fwd(E_rs, 1);
            total++; if (fwd_E_rs !== 2'(e)) begin bad++; $display("FAIL rnd_fers n=%0d got=%0d exp=%0d", n, fwd_E_rs, e); end
            e = exp_fwd(E_rt, 1);
            total++; if (fwd_E_rt !== 2'(e)) begin bad++; $display("FAIL rnd_fert n=%0d got=%0d exp=%0d", n, fwd_E_rt, e); end
            total++; if ({md_busy, md_done, md_err} !== {m_busy(), m_done(), m_err}) begin
                bad++; $display("FAIL rnd_md n=%0d got=%b exp=%b", n, {md_busy, md_done, md_err},
                                {m_busy(), m_done(), m_err});
            end
            total++; if (int'(stall_cnt) !== m_scnt) begin
                bad++; $display("FAIL rnd_scnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_scnt);
            end
            tick();
        end
        reset = 0;
    endtask

    task automatic test_saturation();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        D_rs = 1; D_Tuse_rs = 0; E_WR = 1; RegWrite_E = 1; Tnew_E = 1;
        for (int k = 0; k < MAXC - 1; k++) tick();
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
        for (int k = 0; k < 70000 - (MAXC - 1); k++) tick();
        total++; if (stall_cnt !== 16'hFFFF || int'(stall_cnt) !== m_scnt) begin
            bad++; $display("FAIL sat got=%h exp=ffff", stall_cnt);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #1;
        test_reset();
        test_load_use();
        test_priority();
        test_mult();
        test_div_reset();
        test_restart();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
